w5300_socket_n_tx: RTL and testbench

//   Socket-N transmit engine; runs while the driver FSM is in Transmitting and owns the bus mux slot.

---
 rtl/w5300_socket_n_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_w5300_socket_n_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_socket_n_tx.sv
// Socket-N transmit engine: waits for TX free space, streams the frame from the TX buffer
// into Sn_TX_FIFOR, commits the length via Sn_TX_WRSR and issues SEND through the bus interface.
module w5300_socket_n_tx #(
    parameter int N                   = 0,
    parameter int ETH_TX_BUFFER_WIDTH = 16,
    parameter int FSR_POLL_MAX        = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [15:0]                    tx_len,
    output logic                           done,
    output logic                           error,
    output logic                           busy,
    output logic [10:0]                    addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state,
    output logic [ETH_TX_BUFFER_WIDTH-1:0] buffer_addr,
    input  logic [15:0]                    buffer_data
);
    localparam int              PW        = $clog2(FSR_POLL_MAX + 1);
    localparam logic [PW-1:0]   POLL_LAST = PW'(FSR_POLL_MAX - 1);
    localparam logic [9:0]      BASE      = 10'(32'h200 + N * 32'h40);
    localparam logic            OP_RD     = 1'b1;
    localparam logic            OP_WR     = 1'b0;
    localparam logic [9:0]      R_CR      = 10'h002;
    localparam logic [9:0]      R_WRSR_H  = 10'h020;
    localparam logic [9:0]      R_WRSR_L  = 10'h022;
    localparam logic [9:0]      R_FSR_H   = 10'h024;
    localparam logic [9:0]      R_FSR_L   = 10'h026;
    localparam logic [9:0]      R_FIFO    = 10'h02E;
    localparam logic [10:0]     ADDR_IDLE = {OP_RD, 10'h000};
    localparam logic [15:0]     CMD_SEND  = 16'h0020;

    typedef enum logic [3:0] {
        S_IDLE, S_FSRH, S_FSRL, S_CHECK, S_FETCH, S_FIFO,
        S_WRSRH, S_WRSRL, S_SEND, S_CMDWAIT, S_ERROR
    } state_t;

    function automatic logic [10:0] acc(input logic rd, input logic [9:0] off);
        acc = {rd, BASE + off};
    endfunction

    state_t                         state_q, state_d;
    logic                           en_q, en_d;
    logic [15:0]                    tx_len_q, tx_len_d;
    logic [16:0]                    words_q, words_d;
    logic [16:0]                    fsr_q, fsr_d;
    logic [PW-1:0]                  poll_q, poll_d;
    logic [16:0]                    word_idx_q, word_idx_d;
    logic [ETH_TX_BUFFER_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [10:0]                    addr_q, addr_d;
    logic [15:0]                    wr_data_q, wr_data_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic                           busy_q, busy_d;
    logic                           start;

    assign start = enable & ~en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            tx_len_q   <= '0;
            words_q    <= '0;
            fsr_q      <= '0;
            poll_q     <= '0;
            word_idx_q <= '0;
            buf_addr_q <= '0;
            addr_q     <= ADDR_IDLE;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            tx_len_q   <= tx_len_d;
            words_q    <= words_d;
            fsr_q      <= fsr_d;
            poll_q     <= poll_d;
            word_idx_q <= word_idx_d;
            buf_addr_q <= buf_addr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = enable;
        tx_len_d   = tx_len_q;
        words_d    = words_q;
        fsr_d      = fsr_q;
        poll_d     = poll_q;
        word_idx_d = word_idx_q;
        buf_addr_d = buf_addr_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        error_d    = error_q;
        busy_d     = busy_q;

        // Dropping enable abandons any access in flight; nothing is committed.
        if (state_q != S_IDLE && !enable) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            addr_d  = ADDR_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error_d    = 1'b0;
                        poll_d     = '0;
                        word_idx_d = '0;
                        buf_addr_d = '0;
                        tx_len_d   = tx_len;
                        words_d    = 17'(({1'b0, tx_len} + 17'd1) >> 1);
                        if (tx_len == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_FSRH;
                            busy_d  = 1'b1;
                            addr_d  = acc(OP_RD, R_FSR_H);
                        end
                    end
                end
                S_FSRH: begin
                    if (op_state) begin
                        fsr_d[16] = rd_data[0];
                        state_d   = S_FSRL;
                        addr_d    = acc(OP_RD, R_FSR_L);
                    end
                end
                S_FSRL: begin
                    if (op_state) begin
                        fsr_d[15:0] = rd_data;
                        state_d     = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (fsr_q >= {1'b0, tx_len_q}) begin
                        state_d = S_FETCH;
                    end else if (poll_q == POLL_LAST) begin
                        poll_d  = poll_q + 1'b1;
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        state_d = S_FSRH;
                        addr_d  = acc(OP_RD, R_FSR_H);
                    end
                end
                // buffer_addr already points at this word, so the RAM output is valid now;
                // advancing it here lets the next word prefetch while the FIFO write runs.
                S_FETCH: begin
                    wr_data_d  = buffer_data;
                    buf_addr_d = buf_addr_q + 1'b1;
                    addr_d     = acc(OP_WR, R_FIFO);
                    state_d    = S_FIFO;
                end
                S_FIFO: begin
                    if (op_state) begin
                        word_idx_d = word_idx_q + 17'd1;
                        if (word_idx_q + 17'd1 == words_q) begin
                            state_d   = S_WRSRH;
                            addr_d    = acc(OP_WR, R_WRSR_H);
                            wr_data_d = 16'h0000;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WRSRH: begin
                    if (op_state) begin
                        state_d   = S_WRSRL;
                        addr_d    = acc(OP_WR, R_WRSR_L);
                        wr_data_d = tx_len_q;
                    end
                end
                S_WRSRL: begin
                    if (op_state) begin
                        state_d   = S_SEND;
                        addr_d    = acc(OP_WR, R_CR);
                        wr_data_d = CMD_SEND;
                    end
                end
                S_SEND: begin
                    if (op_state) begin
                        state_d = S_CMDWAIT;
                        addr_d  = acc(OP_RD, R_CR);
                    end
                end
                S_CMDWAIT: begin
                    if (op_state && rd_data[7:0] == 8'h00) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        addr_d  = ADDR_IDLE;
                    end
                end
                S_ERROR: begin
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    addr_d  = ADDR_IDLE;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign error       = error_q;
    assign busy        = busy_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign buffer_addr = buf_addr_q;
endmodule

// File: tb/tb_w5300_socket_n_tx.sv
// Directed bench for w5300_socket_n_tx (socket 1, poll limit 4) with a fixed-latency
// bus responder and a synchronous TX buffer model.
module tb_w5300_socket_n_tx;
    localparam int LAT = 3;
    localparam int BW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   tx_len;
    logic          done, error, busy;
    logic [10:0]   addr;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data;
    logic          op_state;
    logic [BW-1:0] buffer_addr;
    logic [15:0]   buffer_data;

    logic [15:0]   mem [16];
    logic [16:0]   fsr_list [4];
    logic [15:0]   cr_list [4];
    logic [10:0]   log_addr [256];
    logic [15:0]   log_data [256];
    int            log_n;
    int            done_cnt = 0;
    int            total = 0;
    int            bad = 0;

    w5300_socket_n_tx #(.N(1), .ETH_TX_BUFFER_WIDTH(BW), .FSR_POLL_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tx_len(tx_len),
        .done(done), .error(error), .busy(busy),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .op_state(op_state),
        .buffer_addr(buffer_addr), .buffer_data(buffer_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buffer_data <= mem[buffer_addr];

    always @(negedge clk) if (done) done_cnt++;

    // Bus responder: completes whatever access is presented LAT cycles after the previous one.
    initial begin
        int lat, fi, ci;
        op_state = 1'b0;
        rd_data  = 16'h0000;
        log_n    = 0;
        lat = 0; fi = 0; ci = 0;
        forever begin
            @(posedge clk);
            #1;
            op_state = 1'b0;
            rd_data  = 16'hDEAD;
            if (rst_n && busy) begin
                lat++;
                if (lat == LAT) begin
                    lat = 0;
                    if (log_n < 256) begin
                        log_addr[log_n] = addr;
                        log_data[log_n] = wr_data;
                        log_n++;
                    end
                    case (addr)
                        11'h664: rd_data = {15'd0, fsr_list[fi][16]};
                        11'h666: begin rd_data = fsr_list[fi][15:0]; if (fi < 3) fi++; end
                        11'h642: begin rd_data = cr_list[ci]; if (ci < 3) ci++; end
                        default: ;
                    endcase
                    op_state = 1'b1;
                end
            end else begin
                lat = 0; fi = 0; ci = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input int idx, input logic [10:0] ea,
                           input logic [15:0] ed, input bit cd);
        chk({tag, "_addr"}, 32'(log_addr[idx & 255]), 32'(ea));
        if (cd) chk({tag, "_data"}, 32'(log_data[idx & 255]), 32'(ed));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_frame(input logic [15:0] len, output logic to);
        int n;
        tx_len = len;
        enable = 1'b1;
        tick(1);
        n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        to = busy;
    endtask

    task automatic wait_log(input int target, output logic to);
        int n;
        n = 0;
        while (log_n < target && n < 3000) begin
            tick(1);
            n++;
        end
        to = (log_n < target);
    endtask

    initial begin
        logic to;
        int   s, d0;

        rst_n  = 1'b0;
        enable = 1'b0;
        tx_len = 16'd0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        fsr_list = '{17'h02000, 17'h02000, 17'h02000, 17'h02000};
        cr_list  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tick(3);
        chk("rst_addr", 32'(addr), 32'h400);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_buf_addr", 32'(buffer_addr), 32'h0);
        chk("rst_flags", {29'd0, done, error, busy}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Six-byte frame, immediate space, enable held high afterwards.
        mem[0] = 16'hA1A2; mem[1] = 16'hB1B2; mem[2] = 16'hC1C2;
        s = log_n; d0 = done_cnt;
        run_frame(16'd6, to);
        chk("t1_timeout", 32'(to), 32'h0);
        tick(5);
        chk("t1_no_restart", 32'(busy), 32'h0);
        chk("t1_count", 32'(log_n - s), 32'd9);
        chk_ent("t1_fsrh", s + 0, 11'h664, 16'h0, 1'b0);
        chk_ent("t1_fsrl", s + 1, 11'h666, 16'h0, 1'b0);
        chk_ent("t1_w0", s + 2, 11'h26E, 16'hA1A2, 1'b1);
        chk_ent("t1_w1", s + 3, 11'h26E, 16'hB1B2, 1'b1);
        chk_ent("t1_w2", s + 4, 11'h26E, 16'hC1C2, 1'b1);
        chk_ent("t1_wrsrh", s + 5, 11'h260, 16'h0000, 1'b1);
        chk_ent("t1_wrsrl", s + 6, 11'h262, 16'h0006, 1'b1);
        chk_ent("t1_send", s + 7, 11'h242, 16'h0020, 1'b1);
        chk_ent("t1_crrd", s + 8, 11'h642, 16'h0, 1'b0);
        enable = 1'b0;
        tick(2);
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

        // Odd length rounds up to three words.
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3355;
        s = log_n; d0 = done_cnt;
        run_frame(16'd5, to);
        enable = 1'b0;
        tick(2);
        chk("t2_timeout", 32'(to), 32'h0);
        chk("t2_count", 32'(log_n - s), 32'd9);
        chk_ent("t2_w2", s + 4, 11'h26E, 16'h3355, 1'b1);
        chk_ent("t2_wrsrl", s + 6, 11'h262, 16'h0005, 1'b1);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);

        // Zero-length start: done pulse without any bus access.
        s = log_n; d0 = done_cnt;
        run_frame(16'd0, to);
        enable = 1'b0;
        tick(2);
        chk("t0len_done", 32'(done_cnt - d0), 32'd1);
        chk("t0len_count", 32'(log_n - s), 32'd0);
        chk("t0len_busy", 32'(busy), 32'h0);

        // Not enough space twice, then enough.
        fsr_list = '{17'h00004, 17'h00004, 17'h01000, 17'h01000};
        mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h0303; mem[3] = 16'h0404;
        s = log_n; d0 = done_cnt;
        run_frame(16'd8, to);
        enable = 1'b0;
        tick(2);
        chk("t3_timeout", 32'(to), 32'h0);
        chk("t3_count", 32'(log_n - s), 32'd14);
        chk_ent("t3_fsrh3", s + 4, 11'h664, 16'h0, 1'b0);
        chk_ent("t3_fsrl3", s + 5, 11'h666, 16'h0, 1'b0);
        chk_ent("t3_w0", s + 6, 11'h26E, 16'h0101, 1'b1);
        chk_ent("t3_w3", s + 9, 11'h26E, 16'h0404, 1'b1);
        chk("t3_error", 32'(error), 32'h0);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);

        // FSR stuck at zero: poll limit reached.
        fsr_list = '{17'h0, 17'h0, 17'h0, 17'h0};
        s = log_n; d0 = done_cnt;
        run_frame(16'd4, to);
        chk("t4_timeout", 32'(to), 32'h0);
        chk("t4_error", 32'(error), 32'h1);
        chk("t4_count", 32'(log_n - s), 32'd8);
        chk_ent("t4_last", s + 7, 11'h666, 16'h0, 1'b0);
        tick(3);
        chk("t4_hold_busy", 32'(busy), 32'h0);
        chk("t4_no_more", 32'(log_n - s), 32'd8);
        enable = 1'b0;
        tick(2);
        chk("t4_error_sticky", 32'(error), 32'h1);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // Sn_CR still busy for two reads; N=1 addressing throughout.
        fsr_list = '{17'h10000, 17'h10000, 17'h10000, 17'h10000};
        cr_list  = '{16'h0020, 16'h0020, 16'h0000, 16'h0000};
        mem[0] = 16'hABCD;
        s = log_n; d0 = done_cnt;
        run_frame(16'd2, to);
        enable = 1'b0;
        tick(2);
        chk("t5_timeout", 32'(to), 32'h0);
        chk("t5_error_cleared", 32'(error), 32'h0);
        chk("t5_count", 32'(log_n - s), 32'd9);
        chk_ent("t5_w0", s + 2, 11'h26E, 16'hABCD, 1'b1);
        chk_ent("t5_send", s + 5, 11'h242, 16'h0020, 1'b1);
        chk_ent("t5_cr3", s + 8, 11'h642, 16'h0, 1'b0);
        chk("t5_done", 32'(done_cnt - d0), 32'd1);

        // Abort after two of four FIFO writes.
        fsr_list = '{17'h02000, 17'h02000, 17'h02000, 17'h02000};
        cr_list  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        s = log_n; d0 = done_cnt;
        tx_len = 16'd8;
        enable = 1'b1;
        tick(1);
        wait_log(s + 4, to);
        chk("t6_timeout", 32'(to), 32'h0);
        enable = 1'b0;
        tick(1);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_addr_idle", 32'(addr), 32'h400);
        tick(10);
        chk("t6_count", 32'(log_n - s), 32'd4);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset during a FIFO write.
        mem[0] = 16'hA1A2; mem[1] = 16'hB1B2; mem[2] = 16'hC1C2;
        s = log_n;
        tx_len = 16'd6;
        enable = 1'b1;
        tick(1);
        wait_log(s + 3, to);
        chk("t7_timeout", 32'(to), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_addr", 32'(addr), 32'h400);
        chk("t7_wr_data", 32'(wr_data), 32'h0);
        chk("t7_buf_addr", 32'(buffer_addr), 32'h0);
        chk("t7_flags", {29'd0, done, error, busy}, 32'h0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t7_idle_after", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
